// File: rtl/vga_sync_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_sync_gen                                               |
// | Description : Vertical line counter and registered VGA timing decode     |
// |               (sync, visible window, pixel coordinates, frame pulse).    |
// |               Optional frame counter enabled by VGA_FRAME_COUNT_EN.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module vga_sync_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] h_count_in,
  input  logic        en_v_in,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] c_H_VISIBLE  = 16'(H_VISIBLE);
  localparam logic [15:0] c_HS_START   = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] c_HS_END     = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] c_H_TOTAL    = 16'(H_TOTAL);
  localparam logic [9:0]  c_V_VISIBLE  = 10'(V_VISIBLE);
  localparam logic [9:0]  c_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  c_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic        c_SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic        c_SYNC_OFF   = ~c_SYNC_ON;

  logic [9:0] r_v_count;
  logic [9:0] w_v_next;
  logic [9:0] w_line;
  logic       w_h_in_frame;
  logic       w_h_sync_on;
  logic       w_v_sync_on;
  logic       w_active;
  logic       w_frame_start;

  // The decode uses the post-increment line on the strobe cycle so that
  // a new line's outputs begin exactly at h_count_in == 0.
  always_comb begin
    w_v_next      = (r_v_count == c_V_LAST) ? 10'd0 : r_v_count + 10'd1;
    w_line        = en_v_in ? w_v_next : r_v_count;
    w_h_in_frame  = (h_count_in < c_H_TOTAL);
    w_h_sync_on   = w_h_in_frame && (h_count_in >= c_HS_START) && (h_count_in < c_HS_END);
    w_v_sync_on   = (w_line >= c_VS_START) && (w_line < c_VS_END);
    w_active      = (h_count_in < c_H_VISIBLE) && (w_line < c_V_VISIBLE);
    w_frame_start = (h_count_in == 16'd0) && (w_line == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_count <= 10'd0;
    end else if (en_v_in) begin
      r_v_count <= w_v_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync        <= c_SYNC_OFF;
      vsync        <= c_SYNC_OFF;
      video_active <= 1'b0;
      pixel_x      <= 10'd0;
      pixel_y      <= 10'd0;
      frame_start  <= 1'b0;
    end else begin
      hsync        <= w_h_sync_on ? c_SYNC_ON : c_SYNC_OFF;
      vsync        <= w_v_sync_on ? c_SYNC_ON : c_SYNC_OFF;
      video_active <= w_active;
      pixel_x      <= w_active ? h_count_in[9:0] : 10'd0;
      pixel_y      <= w_active ? w_line : 10'd0;
      frame_start  <= w_frame_start;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Counts on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if (w_frame_start) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_sync_gen                                            |
// | Description : Self-checking bench for vga_sync_gen against a line/pixel  |
// |               arithmetic model, with randomized horizontal stimulus.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_vga_sync_gen;

  localparam int V_TOTAL  = 525;
  localparam int HS_START = 640 + 16;
  localparam int HS_END   = 640 + 16 + 96;
  localparam int VS_START = 480 + 10;
  localparam int VS_END   = 480 + 10 + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] h_count_in = 16'd900;
  logic        en_v_in = 1'b0;

  logic        hsync, vsync, video_active, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic        hsync_p, vsync_p, video_active_p, frame_start_p;
  logic [9:0]  pixel_x_p, pixel_y_p;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count, frame_count_p;
`endif

  vga_sync_gen u_dut (
    .clk(clk), .rst(rst), .h_count_in(h_count_in), .en_v_in(en_v_in),
    .hsync(hsync), .vsync(vsync), .video_active(video_active),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  vga_sync_gen #(.SYNC_ACTIVE_LOW(0)) u_dut_pos (
    .clk(clk), .rst(rst), .h_count_in(h_count_in), .en_v_in(en_v_in),
    .hsync(hsync_p), .vsync(vsync_p), .video_active(video_active_p),
    .pixel_x(pixel_x_p), .pixel_y(pixel_y_p), .frame_start(frame_start_p)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count_p)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the line index is plain modular arithmetic, outputs are
  // range tests on (h, line), all delayed by one clock.
  function automatic int line_of(input int v, input logic en);
    return en ? (v + 1) % V_TOTAL : v;
  endfunction
  function automatic logic hs_on(input int h);
    return (h >= HS_START) && (h < HS_END);
  endfunction
  function automatic logic vs_on(input int l);
    return (l >= VS_START) && (l < VS_END);
  endfunction
  function automatic logic act_on(input int h, input int l);
    return (h < 640) && (l < 480);
  endfunction

  int   m_v, e_line, e_px, e_py, e_fc;
  logic e_hs, e_vs, e_act, e_fs;
  int   cur_h, cur_l;
  assign cur_h = int'(h_count_in);
  assign cur_l = line_of(m_v, en_v_in);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 0; e_line <= 0; e_hs <= 1'b1; e_vs <= 1'b1; e_act <= 1'b0;
      e_px <= 0; e_py <= 0; e_fs <= 1'b0; e_fc <= 0;
    end else begin
      m_v    <= cur_l;
      e_line <= cur_l;
      e_hs   <= !hs_on(cur_h);
      e_vs   <= !vs_on(cur_l);
      e_act  <= act_on(cur_h, cur_l);
      e_px   <= act_on(cur_h, cur_l) ? cur_h : 0;
      e_py   <= act_on(cur_h, cur_l) ? cur_l : 0;
      e_fs   <= (cur_h == 0) && (cur_l == 0);
      e_fc   <= ((cur_h == 0) && (cur_l == 0)) ? (e_fc + 1) % 65536 : e_fc;
    end
  end

  logic cmp_on   = 1'b0;
  logic stat_clr = 1'b0;
  int   n_act, n_hs_lo, n_fs, px_min, px_max, py_max, vs_lo_min, vs_lo_max;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("video_active", video_active, e_act);
      check("pixel_x", pixel_x, e_px);
      check("pixel_y", pixel_y, e_py);
      check("frame_start", frame_start, e_fs);
      check("hsync_pos", hsync_p, !e_hs);
      check("vsync_pos", vsync_p, !e_vs);
`ifdef VGA_FRAME_COUNT_EN
      check("frame_count", frame_count, e_fc);
`endif
    end
    if (stat_clr) begin
      n_act <= 0; n_hs_lo <= 0; n_fs <= 0; px_min <= 1023; px_max <= 0;
      py_max <= 0; vs_lo_min <= 1023; vs_lo_max <= 0;
    end else begin
      n_act   <= n_act + (video_active ? 1 : 0);
      n_hs_lo <= n_hs_lo + (!hsync ? 1 : 0);
      n_fs    <= n_fs + (frame_start ? 1 : 0);
      if (video_active && int'(pixel_x) < px_min) px_min <= int'(pixel_x);
      if (video_active && int'(pixel_x) > px_max) px_max <= int'(pixel_x);
      if (int'(pixel_y) > py_max) py_max <= int'(pixel_y);
      if (!vsync && e_line < vs_lo_min) vs_lo_min <= e_line;
      if (!vsync && e_line > vs_lo_max) vs_lo_max <= e_line;
    end
  end

  task automatic step(input int hv, input logic ev);
    @(posedge clk);
    #1;
    h_count_in = hv[15:0];
    en_v_in    = ev;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    @(negedge clk);
    #1 stat_clr = 1'b0;
  endtask

  task automatic goto_line(input int target);
    for (int i = 0; i < 600 && m_v != target; i++) begin
      step(0, 1'b1);
      step(900, 1'b0);
      @(negedge clk);
    end
    check("goto_line", m_v, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hsync"}, hsync, 1'b1);
    check({tag, "_vsync"}, vsync, 1'b1);
    check({tag, "_active"}, video_active, 1'b0);
    check({tag, "_px"}, pixel_x, 0);
    check({tag, "_py"}, pixel_y, 0);
    check({tag, "_fs"}, frame_start, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int hb[9] = '{0, 1, 639, 640, 655, 656, 751, 752, 799};

  initial begin
    repeat (3) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // One complete line, advancing to line 1
    step(900, 1'b0);
    clear_stats();
    for (int h = 0; h < 800; h++) step(h, h == 0);
    step(900, 1'b0);
    @(negedge clk);
    check("line_active_count", n_act, 640);
    check("line_hsync_low_count", n_hs_lo, 96);
    check("line_px_min", px_min, 0);
    check("line_px_max", px_max, 639);

    // Out-of-range horizontal index is blanking and leaves the line alone
    step(5, 1'b0);
    @(negedge clk);
    check("h900_active", video_active, 1'b0);
    check("h900_hsync", hsync, 1'b1);
    step(900, 1'b0);
    @(negedge clk);
    check("after_h900_py", pixel_y, 1);
    check("after_h900_px", pixel_x, 5);
    step(0, 1'b1);
    step(900, 1'b0);
    @(negedge clk);
    check("line2_py", pixel_y, 2);

    // A full frame of compressed lines with the horizontal boundaries
    clear_stats();
    repeat (525) foreach (hb[i]) step(hb[i], hb[i] == 0);
    step(900, 1'b0);
    @(negedge clk);
    check("frame_fs_count", n_fs, 1);
    check("frame_vs_first_line", vs_lo_min, 490);
    check("frame_vs_last_line", vs_lo_max, 491);
    check("frame_py_max", py_max, 479);
    check("frame_hsync_low_count", n_hs_lo, 1050);

    // Wrap from the last line into pixel (0,0)
    goto_line(524);
    step(0, 1'b1);
    step(900, 1'b0);
    @(negedge clk);
    check("wrap_fs", frame_start, 1'b1);
    check("wrap_py", pixel_y, 0);
    check("wrap_px", pixel_x, 0);
    check("wrap_active", video_active, 1'b1);

    // Randomized horizontal sweeps, occasionally with a stray strobe
    repeat (400) begin
      step(0, 1'b1);
      repeat ($urandom_range(2, 8)) begin
        int hv;
        hv = ($urandom_range(0, 2) == 0) ? hb[$urandom_range(0, 8)] : int'($urandom_range(0, 1100));
        step(hv, $urandom_range(0, 49) == 0);
      end
    end

    // Asynchronous reset in the middle of line 200
    goto_line(200);
    step(300, 1'b0);
    step(300, 1'b0);
    @(negedge clk);
    check("pre_rst_active", video_active, 1'b1);
    check("pre_rst_px", pixel_x, 300);
    check("pre_rst_py", pixel_y, 200);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 1'b1);
    step(900, 1'b0);
    @(negedge clk);
    check("post_rst_line", pixel_y, 1);
    check("post_rst_px", pixel_x, 0);

`ifdef VGA_FRAME_COUNT_EN
    repeat (3 * 525) begin
      step(0, 1'b1);
      step(900, 1'b0);
    end
    @(negedge clk);
    check("frame_count_3", frame_count, 3);
`endif

    step(900, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch/sync widths in pixels; H_TOTAL = sum of four = 800.
REQ-003 Parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines; V_TOTAL = 525.
REQ-004 Parameter SYNC_ACTIVE_LOW, 1, selects sync polarity (1 = active-low).
REQ-005 clk  input  1  pixel clock; the only clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 h_count_in  input  16  horizontal pixel index from the horizontal counter stage; it runs 0..H_TOTAL-1.
REQ-008 en_v_in  input  1  line-advance strobe; high for exactly the one cycle in which h_count_in == 0.
REQ-009 hsync  output  1  registered horizontal sync.
REQ-010 vsync  output  1  registered vertical sync.
REQ-011 video_active  output  1  registered; high inside the visible region.
REQ-012 pixel_x  output  10  registered visible column; 0 when not active.
REQ-013 pixel_y  output  10  registered visible row; 0 when not active.
REQ-014 frame_start  output  1  registered single-cycle pulse at pixel (0,0) of each frame.

Function
REQ-015 v_count (internal, 10 bits) SHALL increment on each clk edge where en_v_in = 1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-016 The effective line index L for decode SHALL be the post-increment value when en_v_in = 1, and v_count otherwise, so that line N starts exactly at h_count_in = 0.
REQ-017 All outputs SHALL be registered with exactly 1 cycle latency from the h_count_in / L they decode.
REQ-018 Horizontal sync SHALL be asserted for H_VISIBLE+H_FRONT <= h_count_in < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751 at defaults.
REQ-019 Vertical sync SHALL be asserted for V_VISIBLE+V_FRONT <= L < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491 at defaults.
REQ-020 Asserted level SHALL be 0 when SYNC_ACTIVE_LOW = 1 and 1 otherwise; deasserted level SHALL be the inverse.
REQ-021 video_active SHALL be high iff h_count_in < H_VISIBLE and L < V_VISIBLE.
REQ-022 pixel_x and pixel_y SHALL equal h_count_in[9:0] and L while active, and 0 otherwise.
REQ-023 frame_start SHALL be high for one cycle iff h_count_in == 0 and L == 0.
REQ-024 h_count_in >= H_TOTAL SHALL be treated as blanking: hsync deasserted, video_active low; v_count is unaffected.
REQ-025 en_v_in asserted when h_count_in != 0 SHALL still advance v_count; no error flag is raised.

Reset
REQ-026 While rst is high, v_count SHALL be 0, hsync and vsync SHALL be at their deasserted level, and video_active, pixel_x, pixel_y and frame_start SHALL be 0.
REQ-027 Reset SHALL take effect asynchronously, and release SHALL be sampled on clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the first en_v_in after release advances v_count to line 1.

Configuration
REQ-029 When macro VGA_FRAME_COUNT_EN is defined, output frame_count (16 bits, registered) SHALL exist; it resets to 0, increments in the same cycle frame_start is driven high, and wraps 0xFFFF -> 0.
REQ-030 When VGA_FRAME_COUNT_EN is undefined, the frame_count port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-031 Reset, then drive h_count_in 0..799 with en_v_in at h = 0 -> one cycle later, video_active is high for cycles 0..639, pixel_x = 0..639, and hsync = 0 for h = 656..751 only.
REQ-032 Run 525 full lines -> vsync = 0 exactly during lines 490 and 491, pixel_y reaches 479 at most, and frame_start pulses once per 420000 cycles.
REQ-033 Line-boundary check: at h = 0 with en_v_in = 1 and v_count = 524 -> next cycle frame_start = 1, pixel_y = 0 and pixel_x = 0.
REQ-034 Drive h_count_in = 900 -> video_active = 0 and hsync = 1, with v_count unchanged.
REQ-035 Assert rst at line 200, pixel 300 -> outputs reach their reset values immediately without a clock edge; after release and one en_v_in, the decoded line is 1.
REQ-036 With VGA_FRAME_COUNT_EN defined, run 3 frames -> frame_count = 3; with SYNC_ACTIVE_LOW = 0, the sync pulses are inverted.
